// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reads opcode/operand from a synchronous ROM at PC,
// issues them to execute over valid/ready, steers the PC for increments and jumps.
module fetch_ctrl #(
  parameter logic [7:0] HALT_OP = 8'h7F,
  parameter logic [7:0] JMP_OP  = 8'h80,
  parameter logic [7:0] JZ_OP   = 8'h81
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] PC,
  input  logic [7:0] mem_data,
  input  logic       zero_flag,
  input  logic       exec_ready,
  output logic       LOAD_PC,
  output logic       INCR_PC,
  output logic [7:0] ADDR,
  output logic [7:0] ir,
  output logic [7:0] operand,
  output logic       instr_valid,
  output logic       halted,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] DECODE = 3'd3;
  localparam logic [2:0] OPND   = 3'd4;
  localparam logic [2:0] ISSUE  = 3'd5;
  localparam logic [2:0] HALTED = 3'd6;

  logic [2:0] state, state_nxt;
  logic [7:0] addr_q;
  logic       handshake;
  logic       jump_taken;

  // valid/ready: instr_valid is high for the whole of ISSUE with ir/operand frozen;
  // the transfer happens on the rising edge where instr_valid && exec_ready.
  assign handshake   = (state == ISSUE) && exec_ready;
  assign jump_taken  = (ir == JMP_OP) || ((ir == JZ_OP) && zero_flag);

  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALTED);
  assign INCR_PC     = (state == LATCH) || (state == OPND);
  assign LOAD_PC     = handshake && jump_taken;
  assign ADDR        = LOAD_PC ? operand : addr_q;
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   state_nxt = LATCH;
      LATCH:   state_nxt = DECODE;
      DECODE: begin
        if (ir == HALT_OP)  state_nxt = HALTED;
        else if (ir[7])     state_nxt = OPND;
        else                state_nxt = ISSUE;
      end
      OPND:    state_nxt = ISSUE;
      ISSUE:   if (exec_ready) state_nxt = FETCH;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ir      <= 8'h00;
      operand <= 8'h00;
      addr_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == LATCH) ir <= mem_data;
      if (state == DECODE && ir != HALT_OP && !ir[7]) operand <= 8'h00;
      if (state == OPND) operand <= mem_data;
      // ADDR keeps the last jump target once LOAD_PC drops
      if (LOAD_PC) addr_q <= operand;
    end
  end

  assert property (@(posedge clk) disable iff (!reset) !(LOAD_PC && INCR_PC));
  assert property (@(posedge clk) disable iff (!reset)
                   (state == ISSUE && !exec_ready) |=> $stable(PC));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: external PC register and synchronous ROM, an instruction-level
// reference model (walks the ROM program) and an expected-instruction queue.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset, run, zero_flag, exec_ready, pc_clr;
  logic [7:0] pc, mem_data;
  logic       LOAD_PC, INCR_PC, instr_valid, halted;
  logic [7:0] ADDR, ir, operand;
  logic [2:0] dbg_state;

  logic [7:0]  rom [256];
  logic [15:0] exp_q [$];
  logic [7:0]  m_pc, m_addr;
  bit          m_halted;
  int          n_checks = 0;
  int          n_errors = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .PC(pc), .mem_data(mem_data),
    .zero_flag(zero_flag), .exec_ready(exec_ready), .LOAD_PC(LOAD_PC),
    .INCR_PC(INCR_PC), .ADDR(ADDR), .ir(ir), .operand(operand),
    .instr_valid(instr_valid), .halted(halted), .dbg_state(dbg_state)
  );

  // clock / external PC and ROM
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_data <= rom[pc];
    if (pc_clr)       pc <= 8'h00;
    else if (LOAD_PC) pc <= ADDR;
    else if (INCR_PC) pc <= pc + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b0; run = 1'b0; exec_ready = 1'b0; zero_flag = 1'b0; pc_clr = 1'b1;
    repeat (2) @(negedge clk);
    pc_clr = 1'b0; reset = 1'b1;
    m_pc = 8'h00; m_addr = 8'h00; m_halted = 1'b0;
    exp_q.delete();
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic start();
    @(negedge clk);
    run = 1'b1; exec_ready = 1'b0; #1;
  endtask

  task automatic cyc(input logic r);
    @(negedge clk);
    exec_ready = 1'b0; zero_flag = 1'($urandom_range(0, 1)); run = r; #1;
  endtask

  task automatic expect_halt();
    int cycles = 0;
    logic [7:0] pc_after;
    pc_after = m_pc + 8'd1;
    cyc(1'($urandom_range(0, 1)));
    check("halt_pc_at_fetch", 32'(pc), 32'(m_pc));
    while (!halted && !instr_valid && cycles < 12) begin
      cycles++;
      cyc(1'($urandom_range(0, 1)));
    end
    check("halt_latency", 32'(cycles), 32'd3);
    check("halt_flags", 32'({halted, instr_valid}), 32'b10);
    check("halt_pc", 32'(pc), 32'(pc_after));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = 1'(i % 2); exec_ready = 1'($urandom_range(0, 1)); #1;
      check("halt_hold", 32'({halted, instr_valid, LOAD_PC, INCR_PC, pc}),
            32'({4'b1000, pc_after}));
    end
    m_pc = pc_after;
    m_halted = 1'b1;
  endtask

  // Reference: one instruction at m_pc, optional stall, handshake with zsel (0/1/2=random).
  task automatic expect_instr(input int stall, input int zsel);
    logic [7:0]  op, opnd, nxt, pc_next;
    logic [15:0] exp_i;
    int          len, cycles, incr, load;
    logic        z, taken;
    op = rom[m_pc];
    if (op == 8'h7F) begin
      expect_halt();
      return;
    end
    nxt     = m_pc + 8'd1;
    len     = op[7] ? 2 : 1;
    opnd    = op[7] ? rom[nxt] : 8'h00;
    pc_next = m_pc + 8'(len);
    exp_q.push_back({op, opnd});
    cycles = 0; incr = 0; load = 0;
    cyc(1'($urandom_range(0, 1)));
    check("pc_at_fetch", 32'(pc), 32'(m_pc));
    while (!instr_valid && cycles < 12) begin
      incr += int'(INCR_PC);
      load += int'(LOAD_PC);
      cycles++;
      cyc(1'($urandom_range(0, 1)));
    end
    check("fetch_latency", 32'(cycles), 32'(len + 2));
    check("incr_pulses", 32'(incr), 32'(len));
    check("load_pulses", 32'(load), 32'd0);
    exp_i = exp_q.pop_front();
    check("issue_instr", 32'({ir, operand}), 32'(exp_i));
    z = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      z = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      exec_ready = (s == stall); zero_flag = z; run = 1'($urandom_range(0, 1)); #1;
      if (s < stall)
        check("stall_hold", 32'({instr_valid, LOAD_PC, INCR_PC, ir, operand, pc}),
              32'({1'b1, 1'b0, 1'b0, op, opnd, pc_next}));
    end
    taken = (op == 8'h80) || (op == 8'h81 && z);
    check("handshake_ctrl", 32'({instr_valid, LOAD_PC, INCR_PC}), 32'({1'b1, taken, 1'b0}));
    if (taken) m_addr = opnd;
    check("addr", 32'(ADDR), 32'(m_addr));
    m_pc = taken ? opnd : pc_next;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; exec_ready = 1'b0; zero_flag = 1'b0; pc_clr = 1'b1;
    rom_clear();
    #1;
    check("reset_outputs", 32'({ir, operand, ADDR, instr_valid, halted, LOAD_PC, INCR_PC, dbg_state}), 32'd0);
    do_reset();

    // two one-byte instructions back to back
    rom[0] = 8'h01; rom[1] = 8'h02;
    start(); expect_instr(0, 2); expect_instr(0, 2);

    // unconditional jump
    do_reset(); rom_clear();
    rom[8'h00] = 8'h80; rom[8'h01] = 8'h10; rom[8'h10] = 8'h05;
    start(); expect_instr(0, 2); expect_instr(0, 2);

    // JZ taken, then JZ not taken
    do_reset(); rom_clear();
    rom[8'h00] = 8'h81; rom[8'h01] = 8'h20; rom[8'h02] = 8'h03;
    start(); expect_instr(0, 1); expect_instr(0, 2);
    do_reset();
    start(); expect_instr(0, 0); expect_instr(0, 2);

    // execute stage stalls for 5 cycles
    do_reset(); rom_clear();
    rom[8'h00] = 8'h01;
    start(); expect_instr(5, 2); expect_instr(2, 2);

    // HALT at address 0
    do_reset(); rom_clear();
    rom[8'h00] = 8'h7F;
    start(); expect_instr(0, 2);

    // operand byte at FF, PC wraps to 00
    do_reset(); rom_clear();
    rom[8'h00] = 8'h80; rom[8'h01] = 8'hFE; rom[8'hFE] = 8'h81; rom[8'hFF] = 8'h44;
    start(); expect_instr(0, 2); expect_instr(1, 0); expect_instr(0, 2);

    // tight loop: jump to its own address
    do_reset(); rom_clear();
    rom[8'h00] = 8'h05; rom[8'h01] = 8'h80; rom[8'h02] = 8'h01;
    start();
    for (int i = 0; i < 4; i++) expect_instr(i % 2, 2);

    // asynchronous reset while fetching an operand
    do_reset(); rom_clear();
    rom[8'h00] = 8'h80; rom[8'h01] = 8'h40; rom[8'h40] = 8'h90; rom[8'h41] = 8'h55;
    start(); expect_instr(0, 2);
    repeat (4) cyc(1'b0);
    check("pre_reset_ir", 32'(ir), 32'h90);
    reset = 1'b0; #1;
    check("async_reset", 32'({ir, operand, ADDR, instr_valid, halted, LOAD_PC, INCR_PC, dbg_state}), 32'd0);
    do_reset();
    start(); expect_instr(0, 2); expect_instr(0, 2);

    // randomized programs
    for (int t = 0; t < 20; t++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3)       rom[a] = 8'h7F;
        else if (r < 15) rom[a] = 8'h80;
        else if (r < 30) rom[a] = 8'h81;
        else             rom[a] = 8'($urandom_range(0, 255));
      end
      start();
      for (int i = 0; i < 25 && !m_halted; i++)
        expect_instr($urandom_range(0, 3), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
